// File: rtl/div_seq_ctrl_pkg.sv
// Shared constants and types for the sequential restoring divider.
package div_seq_ctrl_pkg;

  // Default operand width
  localparam int DIV_W = 4;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_seq_ctrl_bsub_w.sv
// N-bit borrow-ripple subtractor: {bout, d} = a - b - bin, one full-subtractor cell per bit.
module bsub_w
  import div_seq_ctrl_pkg::*;
#(
  parameter int N = DIV_W + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout
);

  // borrow chain: bc[i] is the borrow into bit i
  logic [N:0] bc;

  assign bc[0] = bin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
      assign d[gi]      = a[gi] ^ b[gi] ^ bc[gi];
      assign bc[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & bc[gi]);
    end
  endgenerate

  assign bout = bc[N];

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle unsigned restoring divider: one quotient bit per RUN cycle through a shared subtractor.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_zero
);

  localparam int CW = $clog2(W);

  state_t        state_q, state_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Trial subtraction: {R, next dividend bit} - {0, M}
  logic [W:0] sub_a;
  logic [W:0] sub_diff;
  logic       sub_bout;
  logic       unused_diff_msb;

  assign sub_a = {r_q, q_q[W-1]};

  bsub_w #(.N(W + 1)) u_bsub (
    .a    (sub_a),
    .b    ({1'b0, m_q}),
    .bin  (1'b0),
    .d    (sub_diff),
    .bout (sub_bout)
  );

  // When the difference is kept it is below M, so its top bit is always zero.
  assign unused_diff_msb = sub_diff[W];

  // Next-state, datapath and result-register logic
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_d   = dividend;
          m_d   = divisor;
          r_d   = '0;
          cnt_d = CW'(W - 1);
          if (divisor == '0) begin
            state_d = ST_DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Keep the difference on no borrow, otherwise restore the shifted partial remainder
        r_d = sub_bout ? sub_a[W-1:0] : sub_diff[W-1:0];
        q_d = {q_q[W-2:0], ~sub_bout};
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          quot_d  = q_d;
          rem_d   = r_d;
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl against an arithmetic reference model.
module tb_div_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_vec = 0;
  int n_err = 0;

  // last completed result, as the outputs should currently hold it
  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;
  logic         prev_dz = 1'b0;

  div_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One operation: start pulse, then per-cycle busy/done checks and result checks
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int           lat;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    edz = (b == 0);
    eq  = edz ? {W{1'b1}} : W'(int'(a) / int'(b));
    er  = edz ? a : W'(int'(a) % int'(b));
    lat = edz ? 1 : W + 1;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      check($sformatf("%0d/%0d busy_done c%0d", a, b, c), {30'd0, busy, done},
            {30'd0, (c <= lat), (c == lat)});
      if (c < lat)
        check($sformatf("%0d/%0d hold c%0d", a, b, c), {div_zero, quotient, remainder},
              {prev_dz, prev_q, prev_r});
      if (c == lat) begin
        check($sformatf("%0d/%0d quotient", a, b), quotient, eq);
        check($sformatf("%0d/%0d remainder", a, b), remainder, er);
        check($sformatf("%0d/%0d div_zero", a, b), div_zero, edz);
        if (!edz)
          check($sformatf("%0d/%0d identity", a, b), int'(quotient) * int'(b) + int'(remainder), a);
      end
    end
    prev_q = eq; prev_r = er; prev_dz = edz;
    $display("op %0d/%0d -> q=%0d r=%0d dz=%0d", a, b, quotient, remainder, div_zero);
  endtask

  initial begin
    int ndone;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset outputs", {busy, done, div_zero, quotient, remainder}, '0);

    // Directed cases
    do_op(4'd13, 4'd3);
    do_op(4'd7, 4'd0);
    do_op(4'd15, 4'd1);
    do_op(4'd2, 4'd9);
    do_op(4'd15, 4'd15);
    do_op(4'd0, 4'd5);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_op(W'(a), W'(b));

    // Randomized operations
    for (int i = 0; i < 100; i++)
      do_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));

    // start held high; operands changed mid-RUN become the second operation
    ndone = 0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) begin dividend = 4'd6; divisor = 4'd2; end
      check($sformatf("held busy_done c%0d", c), {30'd0, busy, done},
            {30'd0, (c != 6 && c != 12), (c == 5 || c == 11)});
      if (done) ndone++;
      if (c == 5)  check("held first result", {div_zero, quotient, remainder}, {1'b0, 4'd4, 4'd1});
      if (c == 11) check("held second result", {div_zero, quotient, remainder}, {1'b0, 4'd3, 4'd0});
    end
    start = 1'b0;
    $display("held-start: %0d done pulses", ndone);
    check("held done count", ndone, 2);
    prev_q = 4'd3; prev_r = 4'd0; prev_dz = 1'b0;

    // Reset in the middle of 13/3
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort outputs", {busy, done, div_zero, quotient, remainder}, '0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    $display("abort: %0d active cycles after reset", ndone);
    check("abort quiet", ndone, 0);
    prev_q = '0; prev_r = '0; prev_dz = 1'b0;
    do_op(4'd9, 4'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
